// File: rtl/vga_pkg.sv
// Shared VGA timing constants, framebuffer geometry and pixel type for the
// background scanout path.
package vga_pkg;

  // 640x480@60 horizontal timing, in pixel ticks
  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC_W  = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;

  // 640x480@60 vertical timing, in lines
  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC_W  = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;

  // Framebuffer geometry in texels (each texel is 4x4 screen pixels)
  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;

  typedef struct packed {
    logic       flag;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  // Start address of texel row s for a 160-wide framebuffer: s*128 + s*32.
  function automatic logic [14:0] row_base_of(input logic [6:0] s);
    logic [14:0] se;
    se = {8'd0, s};
    return (se << 7) + (se << 5);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider, h/v raster counters, sync/visible decode and the
// frame/row event strobes that drive the address generator.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int H_ACT   = H_VISIBLE,
  parameter int H_FP    = H_FRONT,
  parameter int H_SW    = H_SYNC_W,
  parameter int H_BP    = H_BACK,
  parameter int V_ACT   = V_VISIBLE,
  parameter int V_FP    = V_FRONT,
  parameter int V_SW    = V_SYNC_W,
  parameter int V_BP    = V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       tick_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       vis_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       vis_nxt_o,
  output logic [7:0] col_nxt_o,
  output logic       fs_evt_o,
  output logic       row_evt_o,
  output logic       frame_start_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_ACT + H_FP + H_SW + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACT + V_FP + V_SW + V_BP - 1);
  localparam logic [9:0] H_S0   = 10'(H_ACT + H_FP);
  localparam logic [9:0] H_S1   = 10'(H_ACT + H_FP + H_SW);
  localparam logic [9:0] V_S0   = 10'(V_ACT + V_FP);
  localparam logic [9:0] V_S1   = 10'(V_ACT + V_FP + V_SW);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic             fs_q;
  logic             tick, hwrap, vwrap;

  assign tick  = (div_q == DIV_LAST);
  assign hwrap = (h_q == H_LAST);
  assign vwrap = (v_q == V_LAST);

  // Next raster position; counters only move on the pixel tick
  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    h_d   = hwrap ? 10'd0 : h_q + 10'd1;
    v_d   = v_q;
    if (hwrap) v_d = vwrap ? 10'd0 : v_q + 10'd1;
  end

  // Divider, counters and the one-clk frame_start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      fs_q  <= tick & hwrap & vwrap;
      if (tick) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  end

  assign tick_o        = tick;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign vis_o         = (h_q < 10'(H_ACT)) && (v_q < 10'(V_ACT));
  assign hsync_raw_o   = !((h_q >= H_S0) && (h_q < H_S1));
  assign vsync_raw_o   = !((v_q >= V_S0) && (v_q < V_S1));
  assign vis_nxt_o     = (h_d < 10'(H_ACT)) && (v_d < 10'(V_ACT));
  assign col_nxt_o     = h_d[9:2];
  assign fs_evt_o      = tick & hwrap & vwrap;
  // A new texel row starts every 4th visible line, except line 0 which is
  // seeded by the frame-start event instead.
  assign row_evt_o     = tick & hwrap & (v_d < 10'(V_ACT)) & (v_d[1:0] == 2'd0) &
                         (v_d != 10'd0);
  assign frame_start_o = fs_q;

endmodule

// File: rtl/vram_scanout.sv
// Background VRAM read initiator: walks the 160x120 framebuffer with 4x4
// upscaling and per-frame vertical scroll, and aligns returned words with
// the VGA sync/enable signals one pixel tick after the raster position.
module vram_scanout
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FB_W       = FB_W_DEF,
  parameter int FB_H       = FB_H_DEF,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 13,
  parameter int H_ACT      = H_VISIBLE,
  parameter int H_FP       = H_FRONT,
  parameter int H_SW       = H_SYNC_W,
  parameter int H_BP       = H_BACK,
  parameter int V_ACT      = V_VISIBLE,
  parameter int V_FP       = V_FRONT,
  parameter int V_SW       = V_SYNC_W,
  parameter int V_BP       = V_BACK
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            scroll,
  output logic [ADDR_WIDTH-1:0] vram_addr,
  input  logic [DATA_WIDTH-1:0] vram_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  de,
  output logic [11:0]           rgb,
  output logic                  pix_flag,
  output logic                  frame_start,
  output logic [9:0]            hcount,
  output logic [9:0]            vcount
);

  logic       tick, vis, hs_raw, vs_raw, vis_nxt, fs_evt, row_evt;
  logic [7:0] col_nxt;

  vga_timing #(
    .CLK_DIV(CLK_DIV),
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick_o       (tick),
    .h_o          (hcount),
    .v_o          (vcount),
    .vis_o        (vis),
    .hsync_raw_o  (hs_raw),
    .vsync_raw_o  (vs_raw),
    .vis_nxt_o    (vis_nxt),
    .col_nxt_o    (col_nxt),
    .fs_evt_o     (fs_evt),
    .row_evt_o    (row_evt),
    .frame_start_o(frame_start)
  );

  logic [6:0]            scroll_l_q, scroll_l_d, fb_row_q, fb_row_d, scroll_red;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, addr_q, addr_d;
  pixel_t                pix_q, pix_d;
  logic                  de_q, de_d, hs_q, hs_d, vs_q, vs_d;

  // Scroll beyond the framebuffer height folds back into range
  assign scroll_red = (scroll >= 7'(FB_H)) ? scroll - 7'(FB_H) : scroll;

  // Address generator: frame start seeds the row from the latched scroll,
  // every 4th line steps one texel row with vertical wrap.
  always_comb begin
    scroll_l_d = scroll_l_q;
    fb_row_d   = fb_row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    if (fs_evt) begin
      scroll_l_d = scroll_red;
      fb_row_d   = scroll_red;
      row_base_d = ADDR_WIDTH'(row_base_of(scroll_red));
    end else if (row_evt) begin
      if (fb_row_q == 7'(FB_H - 1)) begin
        fb_row_d   = '0;
        row_base_d = '0;
      end else begin
        fb_row_d   = fb_row_q + 7'd1;
        row_base_d = row_base_q + ADDR_WIDTH'(FB_W);
      end
    end
    if (tick) addr_d = vis_nxt ? row_base_d + ADDR_WIDTH'(col_nxt) : '0;
  end

  // Output stage: the word for the pixel now on the counters arrived at
  // least one clk ago, so it is captured together with that pixel's syncs.
  always_comb begin
    pix_d = pix_q;
    de_d  = de_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick) begin
      pix_d = vis ? pixel_t'(vram_data[12:0]) : '0;
      de_d  = vis;
      hs_d  = hs_raw;
      vs_d  = vs_raw;
    end
  end

  // Scanout state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_l_q <= '0;
      fb_row_q   <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
      de_q       <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
    end else begin
      scroll_l_q <= scroll_l_d;
      fb_row_q   <= fb_row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
      de_q       <= de_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
    end
  end

  assign vram_addr = addr_q;
  assign rgb       = {pix_q.r, pix_q.g, pix_q.b};
  assign pix_flag  = pix_q.flag;
  assign de        = de_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout. Full horizontal timing, shortened
// vertical blanking/visible height so several frames fit in a short run.
module tb_vram_scanout;

  localparam int CD = 2;
  localparam int HT = 800;
  localparam int VT = 10;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  scroll = 7'd0;
  logic        mode = 1'b0;
  logic [14:0] vram_addr;
  logic [12:0] vram_data = 13'd0;
  logic        hsync, vsync, de, pix_flag, frame_start;
  logic [11:0] rgb;
  logic [9:0]  hcount, vcount;

  vram_scanout #(
    .CLK_DIV(CD), .V_ACT(8), .V_FP(0), .V_SW(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scroll(scroll), .vram_addr(vram_addr),
    .vram_data(vram_data), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .pix_flag(pix_flag), .frame_start(frame_start), .hcount(hcount), .vcount(vcount)
  );

  always #5 clk = ~clk;

  // VRAM model: 1-clk registered read; mode 1 forces the flag bit
  always @(posedge clk) vram_data <= mode ? {1'b1, vram_addr[11:0]} : vram_addr[12:0];

  typedef enum int {K_ADDR, K_RGB, K_FLAG, K_DE, K_HS, K_VS, K_HC, K_VC, K_FS} kind_e;
  typedef struct {
    int    due;
    kind_e kind;
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;
  int cyc;
  int fs_cnt = 0, de_cnt = 0, vs_cnt = 0, hs_cnt = 0, hs1_cnt = 0, de1_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic int actual(input kind_e k);
    case (k)
      K_ADDR:  return int'(vram_addr);
      K_RGB:   return int'(rgb);
      K_FLAG:  return int'(pix_flag);
      K_DE:    return int'(de);
      K_HS:    return int'(hsync);
      K_VS:    return int'(vsync);
      K_HC:    return int'(hcount);
      K_VC:    return int'(vcount);
      default: return int'(frame_start);
    endcase
  endfunction

  // Expectation keyed on frame/h/v; outputs lag the counters by one tick
  task automatic ex(input kind_e k, input int f, input int h, input int v,
                    input int e, input string nm);
    exp_t x;
    int   l;
    l = f * FR + v * HT + h;
    x.due  = (k inside {K_RGB, K_FLAG, K_DE, K_HS, K_VS}) ? l + 1 : l;
    x.kind = k;
    x.exp  = e;
    x.name = $sformatf("%s f%0d(%0d,%0d)", nm, f, h, v);
    q.push_back(x);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Monitor: after each pixel tick, pop and compare due expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_start) fs_cnt++;
      if (cyc > 0 && cyc % CD == 0) begin
        int t, o;
        t = cyc / CD;
        o = t - 1;
        if (o < FR) begin
          if (de) de_cnt++;
          if (!vsync) vs_cnt++;
          if (!hsync) hs_cnt++;
          if (o >= HT && o < 2 * HT) begin
            if (!hsync) hs1_cnt++;
            if (de) de1_cnt++;
          end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].due == t) begin
            chk(q[i].name, actual(q[i].kind), q[i].exp);
            q.delete(i);
          end else if (q[i].due < t) begin
            checks++;
            errors++;
            $display("FAIL %s: no sample taken, expected %0d", q[i].name, q[i].exp);
            q.delete(i);
          end
        end
      end
    end
  end

  task automatic wait_tick(input int t);
    int n;
    n = 0;
    while (cyc < t * CD && n < 100000) begin
      @(negedge clk);
      n++;
    end
    if (cyc < t * CD) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: cyc=%0d expected %0d", cyc, t * CD);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " addr"}, int'(vram_addr), 0);
    chk({tag, " rgb"}, int'(rgb), 0);
    chk({tag, " flag"}, int'(pix_flag), 0);
    chk({tag, " de"}, int'(de), 0);
    chk({tag, " hsync"}, int'(hsync), 1);
    chk({tag, " vsync"}, int'(vsync), 1);
    chk({tag, " fs"}, int'(frame_start), 0);
    chk({tag, " hcount"}, int'(hcount), 0);
    chk({tag, " vcount"}, int'(vcount), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");

    // Frame 0: scroll_l = 0, data = addr
    ex(K_ADDR, 0, 4, 0, 1, "addr");
    ex(K_ADDR, 0, 639, 0, 159, "addr");
    ex(K_ADDR, 0, 640, 0, 0, "addr");
    ex(K_ADDR, 0, 0, 4, 160, "addr");
    ex(K_ADDR, 0, 8, 4, 162, "addr");
    ex(K_ADDR, 0, 4, 7, 161, "addr");
    ex(K_RGB, 0, 0, 0, 0, "rgb");
    ex(K_RGB, 0, 4, 0, 'h001, "rgb");
    ex(K_DE, 0, 4, 0, 1, "de");
    ex(K_FLAG, 0, 4, 0, 0, "flag");
    ex(K_RGB, 0, 639, 0, 'h09F, "rgb");
    ex(K_RGB, 0, 0, 4, 'h0A0, "rgb");
    ex(K_DE, 0, 640, 0, 0, "de");
    ex(K_RGB, 0, 700, 0, 0, "rgb");
    ex(K_HS, 0, 655, 0, 1, "hsync");
    ex(K_HS, 0, 656, 0, 0, "hsync");
    ex(K_HS, 0, 751, 0, 0, "hsync");
    ex(K_HS, 0, 752, 0, 1, "hsync");
    ex(K_VS, 0, 0, 7, 1, "vsync");
    ex(K_DE, 0, 0, 7, 1, "de");
    ex(K_VS, 0, 0, 8, 0, "vsync");
    ex(K_DE, 0, 0, 8, 0, "de");
    ex(K_VS, 0, 0, 9, 1, "vsync");
    ex(K_FLAG, 0, 100, 9, 0, "flag");
    ex(K_RGB, 0, 100, 9, 0, "rgb");
    ex(K_HC, 0, 300, 2, 300, "hcount");
    ex(K_VC, 0, 300, 2, 2, "vcount");
    ex(K_HC, 0, 799, 9, 799, "hcount");
    ex(K_VC, 0, 799, 9, 9, "vcount");
    ex(K_FS, 0, 799, 9, 0, "fs");
    // Frame 1: scroll 119 latched, flag forced
    ex(K_FS, 1, 0, 0, 1, "fs");
    ex(K_FS, 1, 1, 0, 0, "fs");
    ex(K_HC, 1, 0, 0, 0, "hcount");
    ex(K_VC, 1, 0, 0, 0, "vcount");
    ex(K_ADDR, 1, 0, 0, 19040, "addr");
    ex(K_ADDR, 1, 639, 0, 19199, "addr");
    ex(K_ADDR, 1, 0, 4, 0, "addr");
    ex(K_ADDR, 1, 12, 4, 3, "addr");
    ex(K_RGB, 1, 0, 0, 'hA60, "rgb");
    ex(K_FLAG, 1, 0, 0, 1, "flag");
    ex(K_RGB, 1, 639, 0, 'hAFF, "rgb");
    ex(K_RGB, 1, 0, 4, 0, "rgb");
    ex(K_FLAG, 1, 0, 4, 1, "flag");
    ex(K_FLAG, 1, 700, 0, 0, "flag");
    ex(K_DE, 1, 700, 0, 0, "de");
    // Frame 2: scroll 125 latched as 5
    ex(K_FS, 2, 0, 0, 1, "fs");
    ex(K_ADDR, 2, 0, 0, 800, "addr");
    ex(K_ADDR, 2, 4, 0, 801, "addr");
    ex(K_RGB, 2, 0, 0, 'h320, "rgb");
    ex(K_FLAG, 2, 0, 0, 1, "flag");

    rst_n = 1'b1;

    wait_tick(2 * HT);
    scroll = 7'd119;
    wait_tick(9 * HT);
    mode = 1'b1;
    wait_tick(FR + 1);
    chk("de ticks frame0", de_cnt, 640 * 8);
    chk("vsync low ticks frame0", vs_cnt, HT);
    chk("hsync low ticks frame0", hs_cnt, 96 * VT);
    chk("hsync low ticks line1", hs1_cnt, 96);
    chk("de ticks line1", de1_cnt, 640);
    wait_tick(FR + 2 * HT);
    scroll = 7'd125;
    wait_tick(2 * FR + HT + 300);
    chk("frame_start pulses", fs_cnt, 2);
    chk("pending before reset", q.size(), 0);

    // Mid-frame reset at (300,1): outputs drop at once, no clock needed
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    q.delete();
    ex(K_ADDR, 0, 4, 0, 1, "post addr");
    ex(K_ADDR, 0, 0, 4, 160, "post addr");
    ex(K_RGB, 0, 0, 0, 0, "post rgb");
    ex(K_FLAG, 0, 0, 0, 1, "post flag");
    ex(K_RGB, 0, 4, 0, 'h001, "post rgb");
    ex(K_FLAG, 0, 4, 0, 1, "post flag");
    ex(K_DE, 0, 4, 0, 1, "post de");
    ex(K_HC, 0, 5, 0, 5, "post hcount");
    ex(K_VC, 0, 5, 0, 0, "post vcount");
    rst_n = 1'b1;
    wait_tick(4 * HT + 20);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never checked, expected %0d", q[0].name, q[0].exp);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
